rgb_fade_ctrl: RTL and testbench

Command-driven fade sequencer for the three-channel RGB LED PWM path. It accepts a target colour and a ramp rate over a valid/ready handshake. It steps each channel's 10-bit duty toward its target at a fixed tick rate and drives the `pwm_duty` bus that feeds the per-channel PWM generators. It sits between any colour source (button logic, pattern ROM, UART command decoder) and the PWM generator instances.

---
 rtl/rgb_fade_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_rgb_fade_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_fade_ctrl.sv
// -----------------------------------------------------------------------------
// rgb_fade_ctrl
//
// Command-driven fade sequencer for the three-channel RGB LED PWM path.
// A command carries a target colour (three 10-bit duties) and a step size.
// A step of zero jumps straight to the target. Any other step starts a fade.
// During a fade, each channel moves toward its target by up to `step` on
// every tick. Ticks are generated at CLK_FRE/STEP_HZ clock cycles.
//
// Parameters
//   CLK_FRE   input clock frequency in Hz
//   STEP_HZ   duty update (tick) rate in Hz; CLK_FRE/STEP_HZ must be >= 2
//   DUTY_MAX  largest legal duty value (must fit in 10 bits); larger
//             targets are clamped to it
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  command can be accepted (combinational, equal to !busy)
//   cmd_rgb    target duties: index 2 = R, 1 = G, 0 = B
//   cmd_step   duty change per tick per channel; 0 = jump immediately
//   abort      stop a fade in progress and hold the current duties
//   pwm_duty   registered duty bus to the PWM generators
//   busy       fade in progress (registered)
//   done       one-cycle pulse when a fade or jump completes (registered)
// -----------------------------------------------------------------------------
module rgb_fade_ctrl #(
  parameter int CLK_FRE  = 27_000_000,
  parameter int STEP_HZ  = 1_000,
  parameter int DUTY_MAX = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0][9:0] cmd_rgb,
  input  logic [3:0]      cmd_step,
  input  logic            abort,
  output logic [2:0][9:0] pwm_duty,
  output logic            busy,
  output logic            done
);

  // Cycles per tick. The prescaler runs 0..TICK_DIV-1.
  localparam int TICK_DIV = CLK_FRE / STEP_HZ;
  localparam int PRESC_W  = $clog2(TICK_DIV);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
  localparam logic [9:0]         DUTY_MAX_V = 10'(DUTY_MAX);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FADE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Clamp a requested duty to the legal range.
  function automatic logic [9:0] clamp_duty(input logic [9:0] raw);
    logic [9:0] res;
    if (raw > DUTY_MAX_V) begin
      res = DUTY_MAX_V;
    end else begin
      res = raw;
    end
    return res;
  endfunction

  // Move cur toward tgt by min(step, |tgt - cur|).
  // The distance is computed 11 bits wide. The applied delta never exceeds
  // the distance, so the 10-bit result cannot wrap or overshoot the target.
  function automatic logic [9:0] step_toward(input logic [9:0] cur,
                                             input logic [9:0] tgt,
                                             input logic [3:0] step);
    logic [10:0] diff;
    logic [9:0]  delta;
    logic [9:0]  res;
    if (tgt >= cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
    end
    if (diff > {7'd0, step}) begin
      delta = {6'd0, step};
    end else begin
      delta = diff[9:0];
    end
    if (tgt >= cur) begin
      res = cur + delta;
    end else begin
      res = cur - delta;
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_r;
  logic [PRESC_W-1:0]  presc_r;
  logic [2:0][9:0]     tgt_r;
  logic [2:0][9:0]     duty_r;
  logic [3:0]          step_r;
  logic                busy_r;
  logic                done_r;

  logic                accept_s;
  logic                tick_s;
  logic                all_at_tgt_s;
  logic [2:0][9:0]     cmd_tgt_s;
  logic [2:0][9:0]     next_duty_s;

  // Handshake decode and clamped command targets.
  always_comb begin
    accept_s  = cmd_valid && !busy_r;
    cmd_tgt_s = '0;
    for (int i = 0; i < 3; i++) begin
      cmd_tgt_s[i] = clamp_duty(cmd_rgb[i]);
    end
  end

  // Tick detection, per-channel next duty and the "all channels arrived" flag.
  // The flag is evaluated on the post-update duties. A command whose targets
  // already match the current duties therefore completes on its first tick.
  always_comb begin
    tick_s       = (state_r == ST_FADE) && (presc_r == PRESC_LAST);
    next_duty_s  = '0;
    all_at_tgt_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_duty_s[i] = step_toward(duty_r[i], tgt_r[i], step_r);
      if (next_duty_s[i] != tgt_r[i]) begin
        all_at_tgt_s = 1'b0;
      end else begin
        all_at_tgt_s = all_at_tgt_s;
      end
    end
  end

  // Tick prescaler. It runs freely and is restarted on every accept.
  // This puts the first tick exactly TICK_DIV edges after the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
    end else if (accept_s) begin
      presc_r <= '0;
    end else if (presc_r == PRESC_LAST) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PRESC_ONE;
    end
  end

  // Sequencer FSM with registered duty, busy and done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      tgt_r   <= '0;
      step_r  <= 4'd0;
      duty_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          busy_r <= 1'b0;
          if (accept_s) begin
            tgt_r  <= cmd_tgt_s;
            step_r <= cmd_step;
            if (cmd_step == 4'd0) begin
              // Jump: land on the target at once and stay idle.
              duty_r <= cmd_tgt_s;
              done_r <= 1'b1;
            end else begin
              state_r <= ST_FADE;
              busy_r  <= 1'b1;
            end
          end
        end
        ST_FADE: begin
          if (abort) begin
            // Abort wins over a coincident tick: duties freeze as they are.
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (tick_s) begin
            duty_r <= next_duty_s;
            if (all_at_tgt_s) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_duty  = duty_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign cmd_ready = !busy_r;

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rgb_fade_ctrl
//
// Self-checking bench for rgb_fade_ctrl with CLK_FRE = 1000 and STEP_HZ = 100,
// which gives TICK_DIV = 10.
// Each scenario task drives commands and checks duties and busy cycle by
// cycle against closed-form expectations.
// Expected completions (final duty plus the cycle of the done pulse) are
// pushed to a scoreboard queue. A monitor pops them when `done` is seen.
// -----------------------------------------------------------------------------
module tb_rgb_fade_ctrl;

  localparam int TICK_DIV = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0][9:0] cmd_rgb;
  logic [3:0]      cmd_step;
  logic            abort;
  logic [2:0][9:0] pwm_duty;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic [2:0][9:0] duty;
    int              cyc;
  } exp_t;

  exp_t sb_q[$];

  rgb_fade_ctrl #(
    .CLK_FRE (1000),
    .STEP_HZ (100),
    .DUTY_MAX(1000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_rgb  (cmd_rgb),
    .cmd_step (cmd_step),
    .abort    (abort),
    .pwm_duty (pwm_duty),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge number e, cyc == e.
  always @(posedge clk) cyc <= cyc + 1;

  // Completion monitor: every done pulse must match the head of the scoreboard.
  initial begin : done_monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && done === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected cyc=%0d got done=1 want done=0", cyc);
        end else begin
          e = sb_q.pop_front();
          if (cyc !== e.cyc || pwm_duty !== e.duty) begin
            errors++;
            $display("FAIL done_event got cyc=%0d duty=%0d,%0d,%0d want cyc=%0d duty=%0d,%0d,%0d",
                     cyc, pwm_duty[2], pwm_duty[1], pwm_duty[0],
                     e.cyc, e.duty[2], e.duty[1], e.duty[0]);
          end
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got time=%0t want finish before 500000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0][9:0] duty, input int at_cyc);
    exp_t e;
    e.duty = duty;
    e.cyc  = at_cyc;
    sb_q.push_back(e);
  endtask

  // Present a command, wait (bounded) for ready, and return the accept edge.
  task automatic drive_cmd(input logic [2:0][9:0] rgb, input logic [3:0] stp, output int k);
    int n;
    n         = 0;
    cmd_rgb   = rgb;
    cmd_step  = stp;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 2000) begin
      step_clk();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout got ready=%b want 1", cmd_ready);
    end
    step_clk();
    k         = cyc;
    cmd_valid = 1'b0;
  endtask

  // Cycle-by-cycle check of a fade accepted at edge k (called right after k).
  task automatic check_fade(input logic [2:0][9:0] start, input logic [2:0][9:0] tgt,
                            input int stp, input int k, input string name);
    int t_max, d, ti, n, mv, s, t, lim;
    logic [2:0][9:0] e;
    t_max = 1;
    for (int i = 0; i < 3; i++) begin
      s = int'(start[i]);
      t = int'(tgt[i]);
      d = (t > s) ? t - s : s - t;
      ti = (d + stp - 1) / stp;
      if (ti > t_max) t_max = ti;
    end
    lim = t_max * TICK_DIV;
    push_exp(tgt, k + lim);
    for (int j = 0; j <= lim + 1; j++) begin
      n = j / TICK_DIV;
      for (int i = 0; i < 3; i++) begin
        s  = int'(start[i]);
        t  = int'(tgt[i]);
        d  = (t > s) ? t - s : s - t;
        mv = n * stp;
        if (mv > d) mv = d;
        e[i] = (t > s) ? 10'(s + mv) : 10'(s - mv);
      end
      checks++;
      if (pwm_duty !== e) begin
        errors++;
        $display("FAIL %s_duty cyc=k+%0d got %0d,%0d,%0d want %0d,%0d,%0d", name, j,
                 pwm_duty[2], pwm_duty[1], pwm_duty[0], e[2], e[1], e[0]);
      end
      checks++;
      if (busy !== (j < lim)) begin
        errors++;
        $display("FAIL %s_busy cyc=k+%0d got %b want %b", name, j, busy, (j < lim));
      end
      step_clk();
    end
  endtask

  task automatic test_reset();
    #12;
    rst_n  = 1'b0;
    mon_en = 1'b1;
    #1;
    checks++;
    if ({pwm_duty, busy, done, cmd_ready} !== {30'd0, 3'b001}) begin
      errors++;
      $display("FAIL reset_async got duty=%h busy=%b done=%b ready=%b want duty=0 busy=0 done=0 ready=1",
               pwm_duty, busy, done, cmd_ready);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({pwm_duty, busy, done, cmd_ready} !== {30'd0, 3'b001}) begin
        errors++;
        $display("FAIL reset_hold got duty=%h busy=%b done=%b ready=%b want 0,0,0,1",
                 pwm_duty, busy, done, cmd_ready);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step_clk();
    checks++;
    if ({pwm_duty, busy, done, cmd_ready} !== {30'd0, 3'b001}) begin
      errors++;
      $display("FAIL reset_release got duty=%h busy=%b done=%b ready=%b want 0,0,0,1",
               pwm_duty, busy, done, cmd_ready);
    end
  endtask

  task automatic test_up_fade();
    int k;
    drive_cmd({10'd100, 10'd50, 10'd0}, 4'd10, k);
    check_fade('0, {10'd100, 10'd50, 10'd0}, 10, k, "up");
  endtask

  task automatic test_clamp_jump();
    int k;
    drive_cmd({10'd1023, 10'd1023, 10'd1023}, 4'd0, k);
    push_exp({10'd1000, 10'd1000, 10'd1000}, k);
    checks++;
    if (pwm_duty !== {10'd1000, 10'd1000, 10'd1000} || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL jump_land got duty=%0d,%0d,%0d busy=%b done=%b want 1000,1000,1000 busy=0 done=1",
               pwm_duty[2], pwm_duty[1], pwm_duty[0], busy, done);
    end
    repeat (3) begin
      step_clk();
      checks++;
      if (pwm_duty !== {10'd1000, 10'd1000, 10'd1000} || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL jump_hold got duty=%0d,%0d,%0d busy=%b done=%b want 1000,1000,1000 busy=0 done=0",
                 pwm_duty[2], pwm_duty[1], pwm_duty[0], busy, done);
      end
    end
  endtask

  task automatic test_down_fade();
    int k;
    drive_cmd({10'd7, 10'd7, 10'd7}, 4'd15, k);
    check_fade({10'd1000, 10'd1000, 10'd1000}, {10'd7, 10'd7, 10'd7}, 15, k, "down");
  endtask

  task automatic test_abort_backpressure();
    int k;
    // Return to black first so the fade starts from 0.
    drive_cmd('0, 4'd0, k);
    push_exp('0, k);
    step_clk();
    drive_cmd({10'd500, 10'd0, 10'd0}, 4'd10, k);
    // A second command (a jump, B clamped) is held valid for the whole fade.
    cmd_rgb   = {10'd200, 10'd300, 10'd1010};
    cmd_step  = 4'd0;
    cmd_valid = 1'b1;
    for (int j = 0; j < 30; j++) begin
      checks++;
      if (pwm_duty !== {10'(10 * (j / TICK_DIV)), 10'd0, 10'd0} || busy !== 1'b1 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL abort_fading cyc=k+%0d got R=%0d G=%0d B=%0d busy=%b ready=%b want R=%0d G=0 B=0 busy=1 ready=0",
                 j, pwm_duty[2], pwm_duty[1], pwm_duty[0], busy, cmd_ready, 10 * (j / TICK_DIV));
      end
      if (j == 29) abort = 1'b1;
      step_clk();
    end
    abort = 1'b0;
    checks++;
    if (pwm_duty !== {10'd20, 10'd0, 10'd0} || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_hold got R=%0d G=%0d B=%0d busy=%b ready=%b want R=20 G=0 B=0 busy=0 ready=1",
               pwm_duty[2], pwm_duty[1], pwm_duty[0], busy, cmd_ready);
    end
    push_exp({10'd200, 10'd300, 10'd1000}, k + 31);
    step_clk();
    cmd_valid = 1'b0;
    checks++;
    if (pwm_duty !== {10'd200, 10'd300, 10'd1000} || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_pending_accept got duty=%0d,%0d,%0d busy=%b want 200,300,1000 busy=0",
               pwm_duty[2], pwm_duty[1], pwm_duty[0], busy);
    end
    step_clk();
  endtask

  task automatic test_reset_mid_fade();
    int k;
    drive_cmd({10'd300, 10'd300, 10'd300}, 4'd5, k);
    repeat (39) step_clk();
    checks++;
    if (pwm_duty !== {10'd215, 10'd300, 10'd985} || busy !== 1'b1) begin
      errors++;
      $display("FAIL midfade_progress got duty=%0d,%0d,%0d busy=%b want 215,300,985 busy=1",
               pwm_duty[2], pwm_duty[1], pwm_duty[0], busy);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pwm_duty, busy, done, cmd_ready} !== {30'd0, 3'b001}) begin
      errors++;
      $display("FAIL midfade_reset got duty=%h busy=%b done=%b ready=%b want 0,0,0,1",
               pwm_duty, busy, done, cmd_ready);
    end
    repeat (2) step_clk();
    rst_n = 1'b1;
    repeat (12) begin
      step_clk();
      checks++;
      if ({pwm_duty, busy, done, cmd_ready} !== {30'd0, 3'b001}) begin
        errors++;
        $display("FAIL midfade_release got duty=%h busy=%b done=%b ready=%b want 0,0,0,1",
                 pwm_duty, busy, done, cmd_ready);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    cmd_rgb   = '0;
    cmd_step  = 4'd0;
    test_reset();
    test_up_fade();
    test_clamp_jump();
    test_down_fade();
    test_abort_backpressure();
    test_reset_mid_fade();
    repeat (3) step_clk();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending completions want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
